// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared sizes and state encoding for the FIR sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int NUM_BANK = 4;
    localparam int NUM_TAP  = 10;
    localparam int BANK_W   = 2;
    localparam int TAP_W    = 4;
    localparam int DATA_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_seq_ctrl_if
//  Description : Request, coefficient, SRAM and MAC signals of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_seq_ctrl_if;
    import fir_pkg::*;

    logic              iCoeffUpdate;
    logic              iCoeffWrEn;
    logic [DATA_W-1:0] iCoeffData;
    logic              iInValid;
    logic              oBusy;
    logic              oCoeffLoaded;
    logic [BANK_W-1:0] oModuleSel;
    logic              oCsnRam;
    logic              oWrnRam;
    logic [TAP_W-1:0]  oAddrRam;
    logic [DATA_W-1:0] oWtDtRam;
    logic              oEnMul;
    logic              oEnAddAcc;
    logic              oOutValid;

    modport slave (
        input  iCoeffUpdate, iCoeffWrEn, iCoeffData, iInValid,
        output oBusy, oCoeffLoaded, oModuleSel, oCsnRam, oWrnRam,
               oAddrRam, oWtDtRam, oEnMul, oEnAddAcc, oOutValid
    );

    modport master (
        output iCoeffUpdate, iCoeffWrEn, iCoeffData, iInValid,
        input  oBusy, oCoeffLoaded, oModuleSel, oCsnRam, oWrnRam,
               oAddrRam, oWtDtRam, oEnMul, oEnAddAcc, oOutValid
    );

endinterface
`default_nettype wire

// File: rtl/fir_tap_bank_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_bank_cnt
//  Description : Nested counter; tap runs 0..NUM_TAP-1, bank steps on tap wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_bank_cnt
    import fir_pkg::*;
(
    input  wire               i_clk,
    input  wire               i_rst,
    input  wire               i_clear,
    input  wire               i_advance,
    output logic [TAP_W-1:0]  o_tap,
    output logic [BANK_W-1:0] o_bank,
    output logic              o_last_tap,
    output logic              o_last_bank
);

    logic [TAP_W-1:0]  r_tap;
    logic [BANK_W-1:0] r_bank;

    // Clear wins over advance; a tap wrap carries into the bank count.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_tap  <= '0;
            r_bank <= '0;
        end else if (i_advance) begin
            if (o_last_tap) begin
                r_tap  <= '0;
                r_bank <= r_bank + BANK_W'(1);
            end else begin
                r_tap  <= r_tap + TAP_W'(1);
            end
        end
    end

    assign o_tap       = r_tap;
    assign o_bank      = r_bank;
    assign o_last_tap  = (r_tap == TAP_W'(NUM_TAP - 1));
    assign o_last_bank = (r_bank == BANK_W'(NUM_BANK - 1));

endmodule
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fir_seq_ctrl
//  Description : Sequences coefficient loads into tap SRAMs and the per-bank
//                read / multiply / accumulate pass of one FIR computation.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_seq_ctrl
    import fir_pkg::*;
(
    input  wire           iClk,
    input  wire           iRst,
    fir_seq_ctrl_if.slave bus
);

    state_t            r_state, w_state_nxt;
    logic              r_drain_cnt, w_drain_cnt_nxt;
    logic              r_coeff_loaded, w_coeff_loaded_nxt;
    logic              r_csn, w_csn_nxt;
    logic              r_wrn, w_wrn_nxt;
    logic [BANK_W-1:0] r_mod_sel, w_mod_sel_nxt;
    logic [TAP_W-1:0]  r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_en_mul, w_en_mul_nxt;
    logic              r_en_add, w_en_add_nxt;
    logic              r_out_valid, w_out_valid_nxt;

    logic              w_cnt_clear, w_cnt_adv;
    logic [TAP_W-1:0]  w_tap;
    logic [BANK_W-1:0] w_bank;
    logic              w_last_tap, w_last_bank;

    fir_tap_bank_cnt u_cnt (
        .i_clk       (iClk),
        .i_rst       (iRst),
        .i_clear     (w_cnt_clear),
        .i_advance   (w_cnt_adv),
        .o_tap       (w_tap),
        .o_bank      (w_bank),
        .o_last_tap  (w_last_tap),
        .o_last_bank (w_last_bank)
    );

    // Next state plus the SRAM/MAC values to present during the next cycle.
    // During READ the counter holds the tap visible now, so the next read
    // address is tap+1; during LOAD it holds the slot of the next write.
    always_comb begin
        w_state_nxt        = r_state;
        w_drain_cnt_nxt    = 1'b0;
        w_coeff_loaded_nxt = r_coeff_loaded;
        w_cnt_clear        = 1'b0;
        w_cnt_adv          = 1'b0;
        w_csn_nxt          = 1'b1;
        w_wrn_nxt          = 1'b1;
        w_mod_sel_nxt      = '0;
        w_addr_nxt         = '0;
        w_wdata_nxt        = '0;
        w_out_valid_nxt    = 1'b0;
        // One-cycle SRAM read latency, then one more stage into the adder.
        w_en_mul_nxt       = ~r_csn & r_wrn;
        w_en_add_nxt       = r_en_mul;

        case (r_state)
            ST_IDLE: begin
                if (bus.iCoeffUpdate) begin
                    w_state_nxt        = ST_LOAD;
                    w_cnt_clear        = 1'b1;
                    w_coeff_loaded_nxt = 1'b0;
                end else if (bus.iInValid && r_coeff_loaded) begin
                    w_state_nxt = ST_READ;
                    w_cnt_clear = 1'b1;
                    w_csn_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.iCoeffWrEn) begin
                    w_csn_nxt     = 1'b0;
                    w_wrn_nxt     = 1'b0;
                    w_mod_sel_nxt = w_bank;
                    w_addr_nxt    = w_tap;
                    w_wdata_nxt   = bus.iCoeffData;
                    w_cnt_adv     = 1'b1;
                    if (w_last_tap && w_last_bank) begin
                        w_state_nxt        = ST_IDLE;
                        w_coeff_loaded_nxt = 1'b1;
                    end
                end
            end
            ST_READ: begin
                w_mod_sel_nxt = w_bank;
                if (w_last_tap) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_csn_nxt  = 1'b0;
                    w_addr_nxt = w_tap + TAP_W'(1);
                    w_cnt_adv  = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Bank select is held so the trailing enables reach this bank.
                w_mod_sel_nxt   = w_bank;
                w_drain_cnt_nxt = 1'b1;
                if (r_drain_cnt) begin
                    w_drain_cnt_nxt = 1'b0;
                    if (w_last_bank) begin
                        w_state_nxt     = ST_DONE;
                        w_out_valid_nxt = 1'b1;
                        w_mod_sel_nxt   = '0;
                    end else begin
                        w_state_nxt   = ST_READ;
                        w_cnt_adv     = 1'b1;
                        w_csn_nxt     = 1'b0;
                        w_mod_sel_nxt = w_bank + BANK_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, load flag and registered outputs; reset abandons any operation.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state        <= ST_IDLE;
            r_drain_cnt    <= 1'b0;
            r_coeff_loaded <= 1'b0;
            r_csn          <= 1'b1;
            r_wrn          <= 1'b1;
            r_mod_sel      <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_en_mul       <= 1'b0;
            r_en_add       <= 1'b0;
            r_out_valid    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_drain_cnt    <= w_drain_cnt_nxt;
            r_coeff_loaded <= w_coeff_loaded_nxt;
            r_csn          <= w_csn_nxt;
            r_wrn          <= w_wrn_nxt;
            r_mod_sel      <= w_mod_sel_nxt;
            r_addr         <= w_addr_nxt;
            r_wdata        <= w_wdata_nxt;
            r_en_mul       <= w_en_mul_nxt;
            r_en_add       <= w_en_add_nxt;
            r_out_valid    <= w_out_valid_nxt;
        end
    end

    assign bus.oBusy        = (r_state != ST_IDLE);
    assign bus.oCoeffLoaded = r_coeff_loaded;
    assign bus.oModuleSel   = r_mod_sel;
    assign bus.oCsnRam      = r_csn;
    assign bus.oWrnRam      = r_wrn;
    assign bus.oAddrRam     = r_addr;
    assign bus.oWtDtRam     = r_wdata;
    assign bus.oEnMul       = r_en_mul;
    assign bus.oEnAddAcc    = r_en_add;
    assign bus.oOutValid    = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_seq_ctrl
//  Description : Directed self-checking bench for fir_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_seq_ctrl;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    fir_seq_ctrl_if bus ();

    fir_seq_ctrl dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk(input logic busy, input logic loaded,
                                       input logic csn, input logic wrn,
                                       input logic [1:0] sel, input logic [3:0] addr,
                                       input logic mul, input logic add,
                                       input logic ov, input logic [15:0] data);
        return {3'b000, busy, loaded, csn, wrn, sel, addr, mul, add, ov, data};
    endfunction

    function automatic logic [31:0] obs();
        return pk(bus.oBusy, bus.oCoeffLoaded, bus.oCsnRam, bus.oWrnRam,
                  bus.oModuleSel, bus.oAddrRam, bus.oEnMul, bus.oEnAddAcc,
                  bus.oOutValid, bus.oWtDtRam);
    endfunction

    task automatic start_load();
        bus.iCoeffUpdate = 1'b1;
        tick();
        bus.iCoeffUpdate = 1'b0;
        check("load_start", obs(), pk(1, 0, 1, 1, 2'd0, 4'd0, 0, 0, 0, 16'h0));
    endtask

    // Writes 0x0001..0x0028, optionally with a WrEn-low gap before each word.
    task automatic write_coeffs(input bit gaps);
        for (int i = 0; i < 40; i++) begin
            if (gaps) begin
                bus.iCoeffWrEn = 1'b0;
                tick();
                check("load_gap", {28'h0, bus.oBusy, bus.oCoeffLoaded, bus.oCsnRam, bus.oWrnRam},
                      {28'h0, 4'b1011});
                check("load_gap_data", {16'h0, bus.oWtDtRam}, 32'h0);
            end
            bus.iCoeffWrEn = 1'b1;
            bus.iCoeffData = 16'(i + 1);
            tick();
            bus.iCoeffWrEn = 1'b0;
            bus.iCoeffData = 16'h0;
            check("load_wr", obs(), pk(i != 39, i == 39, 0, 0, 2'(i / 10), 4'(i % 10),
                                      0, 0, 0, 16'(i + 1)));
        end
    endtask

    task automatic quiet_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check(tag, {29'h0, bus.oBusy, bus.oCsnRam, bus.oEnMul}, {29'h0, 3'b010});
            tick();
        end
    endtask

    // One computation; cycle c is the c-th cycle after the iInValid edge.
    task automatic run_compute(input bit disturb, input int abort_at);
        int  n_rd, n_mul, n_add;
        int  b, r;
        bit  rd, mul, add;
        n_rd = 0; n_mul = 0; n_add = 0;
        bus.iInValid = 1'b1;
        tick();
        bus.iInValid = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            b   = (c - 1) / 12;
            r   = (c - 1) % 12;
            rd  = (c <= 48) && (r < 10);
            mul = (c >= 2) && (c - 1 <= 48) && (((c - 2) % 12) < 10);
            add = (c >= 3) && (c - 2 <= 48) && (((c - 3) % 12) < 10);
            check("compute", obs(), pk(c <= 49, 1, !rd, 1, (c <= 48) ? 2'(b) : 2'd0,
                                       rd ? 4'(r) : 4'd0, mul, add, c == 49, 16'h0));
            if (!bus.oCsnRam && bus.oWrnRam) n_rd++;
            if (bus.oEnMul)    n_mul++;
            if (bus.oEnAddAcc) n_add++;
            if (c == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_mid_read", obs(), pk(0, 0, 1, 1, 2'd0, 4'd0, 0, 0, 0, 16'h0));
                return;
            end
            if (disturb && (c == 5 || c == 20 || c == 36 || c == 47 || c == 49)) begin
                bus.iInValid     = 1'b1;
                bus.iCoeffUpdate = 1'b1;
                bus.iCoeffWrEn   = 1'b1;
                bus.iCoeffData   = 16'hBEEF;
            end
            tick();
            bus.iInValid     = 1'b0;
            bus.iCoeffUpdate = 1'b0;
            bus.iCoeffWrEn   = 1'b0;
            bus.iCoeffData   = 16'h0;
        end
        check("read_count", n_rd, 40);
        check("mul_count", n_mul, 40);
        check("add_count", n_add, 40);
    endtask

    initial begin
        rst              = 1'b1;
        bus.iCoeffUpdate = 1'b0;
        bus.iCoeffWrEn   = 1'b0;
        bus.iCoeffData   = 16'h0;
        bus.iInValid     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", obs(), pk(0, 0, 1, 1, 2'd0, 4'd0, 0, 0, 0, 16'h0));

        // Sample before any load is dropped.
        bus.iInValid = 1'b1;
        tick();
        bus.iInValid = 1'b0;
        quiet_check("no_load_ignored", 12);

        // Back-to-back load, then a clean computation.
        start_load();
        write_coeffs(1'b0);
        tick();
        check("post_load_idle", obs(), pk(0, 1, 1, 1, 2'd0, 4'd0, 0, 0, 0, 16'h0));
        run_compute(1'b0, 0);

        // Gapped load, then a computation with ignored requests during it.
        start_load();
        write_coeffs(1'b1);
        run_compute(1'b1, 0);

        // Update and sample together: the update wins, no reads issued.
        bus.iInValid     = 1'b1;
        bus.iCoeffUpdate = 1'b1;
        tick();
        bus.iInValid     = 1'b0;
        bus.iCoeffUpdate = 1'b0;
        check("upd_wins", obs(), pk(1, 0, 1, 1, 2'd0, 4'd0, 0, 0, 0, 16'h0));
        for (int k = 0; k < 12; k++) begin
            check("upd_no_read", {29'h0, bus.oBusy, bus.oCsnRam, bus.oEnMul}, {29'h0, 3'b110});
            tick();
        end

        // Finish that load, then reset while bank 2 tap 5 is being read.
        write_coeffs(1'b0);
        run_compute(1'b0, 30);
        bus.iInValid = 1'b1;
        tick();
        bus.iInValid = 1'b0;
        quiet_check("post_rst_ignored", 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
